// File: rtl/conv_window_buffer.sv
// conv_window_buffer
//   Raster-order pixel stream in, every valid KxK window (stride 1, no
//   padding) out, with the window's output row/column. Storage is K-1 line
//   buffers plus a KxK shift-register window. Pixel data passes through
//   bit-exact.
//
// Ports
//   clk, rst     : clock; synchronous active-high reset
//   pix_in       : input pixel, raster order (DATA_W bits)
//   pix_valid    : pix_in valid
//   pix_ready    : pixel accepted this cycle when pix_valid is also high
//   window_out   : element [r][c] at bits (r*K+c)*DATA_W, r=0 top row,
//                  c=0 leftmost column
//   win_valid    : window_out valid
//   win_ready    : downstream accepts the window
//   win_row      : window row index (0..IMG_H-K)
//   win_col      : window column index (0..IMG_W-K)
//   win_last     : high with the final window of a frame
//   stall_cnt    : only with WINBUF_STALL_CNT_EN defined; saturating count
//                  of cycles with win_valid && !win_ready, cleared by rst
//
// Build option: `define WINBUF_STALL_CNT_EN to add the stall_cnt port.
module conv_window_buffer #(
   parameter int DATA_W = 16,
   parameter int K      = 5,
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     pix_in,
   input  logic                  pix_valid,
   output logic                  pix_ready,
   output logic [K*K*DATA_W-1:0] window_out,
   output logic                  win_valid,
   input  logic                  win_ready,
   output logic [15:0]           win_row,
   output logic [15:0]           win_col,
   output logic                  win_last
`ifdef WINBUF_STALL_CNT_EN
   ,
   output logic [31:0]           stall_cnt
`endif
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_WIN       = CW'(K - 1);
   localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_FILL_LAST = RW'(K - 2);
   localparam logic [15:0]   OFFS          = 16'(K - 1);

   typedef enum logic {FILL, STREAM} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic [DATA_W-1:0] lb_q  [K-1][IMG_W];
   logic [DATA_W-1:0] win_q [K][K];
   logic [DATA_W-1:0] win_d [K][K];
   logic [DATA_W-1:0] new_col [K];
   logic              win_valid_q, win_valid_d;
   logic              win_last_q, win_last_d;
   logic [15:0]       win_row_q, win_row_d;
   logic [15:0]       win_col_q, win_col_d;
   logic              accept, emit, end_of_row, end_of_frame;

   assign pix_ready    = !win_valid_q || win_ready;
   assign accept       = pix_valid && pix_ready;
   assign end_of_row   = (col_q == COL_LAST);
   assign end_of_frame = end_of_row && (row_q == ROW_LAST);
   // STREAM is exactly "row >= K-1", so only the column needs checking here.
   assign emit         = (state_q == STREAM) && (col_q >= COL_WIN);

   // Column entering the window: oldest line buffer at the top, live pixel
   // at the bottom.
   always_comb begin
      for (int unsigned r = 0; r < K; r++) new_col[r] = '0;
      for (int unsigned r = 0; r < K - 1; r++) new_col[r] = lb_q[K-2-r][col_q];
      new_col[K-1] = pix_in;
   end

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      win_d       = win_q;
      win_row_d   = win_row_q;
      win_col_d   = win_col_q;
      win_last_d  = win_last_q;
      win_valid_d = win_valid_q && !win_ready;

      if (accept) begin
         for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
            win_d[r][K-1] = new_col[r];
         end

         if (end_of_row) begin
            col_d = '0;
            row_d = end_of_frame ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end

         case (state_q)
            FILL:    if (end_of_row && row_q == ROW_FILL_LAST) state_d = STREAM;
            STREAM:  if (end_of_frame) state_d = FILL;
            default: state_d = FILL;
         endcase

         // Accept implies the previous window (if any) was taken this edge,
         // so the new window simply replaces it.
         win_valid_d = emit;
         if (emit) begin
            win_row_d  = 16'(row_q) - OFFS;
            win_col_d  = 16'(col_q) - OFFS;
            win_last_d = end_of_frame;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FILL;
         col_q       <= '0;
         row_q       <= '0;
         win_valid_q <= 1'b0;
         win_last_q  <= 1'b0;
         win_row_q   <= '0;
         win_col_q   <= '0;
         for (int unsigned r = 0; r < K; r++)
            for (int unsigned c = 0; c < K; c++) win_q[r][c] <= '0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         win_valid_q <= win_valid_d;
         win_last_q  <= win_last_d;
         win_row_q   <= win_row_d;
         win_col_q   <= win_col_d;
         win_q       <= win_d;
      end
   end

   // Line buffers are plain storage with no reset; stale contents only ever
   // reach the window during FILL, when no window is emitted.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb_q[0][col_q] <= pix_in;
         for (int unsigned i = 1; i < K - 1; i++) lb_q[i][col_q] <= lb_q[i-1][col_q];
      end
   end

   always_comb begin
      window_out = '0;
      for (int unsigned r = 0; r < K; r++)
         for (int unsigned c = 0; c < K; c++)
            window_out[(r*K+c)*DATA_W +: DATA_W] = win_q[r][c];
   end

   assign win_valid = win_valid_q;
   assign win_row   = win_row_q;
   assign win_col   = win_col_q;
   assign win_last  = win_last_q;

`ifdef WINBUF_STALL_CNT_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if (win_valid_q && !win_ready && stall_cnt_q != '1) begin
         stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_conv_window_buffer.sv
// tb_conv_window_buffer
//   Directed bench for conv_window_buffer on an 8x8 image with K=5. A
//   frame-level model (image array, window = image slice) predicts every
//   window; one negedge process compares DUT output against it. Literal
//   checks pin a few hand-computed windows. With WINBUF_STALL_CNT_EN defined
//   the stall_cnt port is connected and checked.
module tb_conv_window_buffer;

   localparam int DW = 16;
   localparam int K  = 5;
   localparam int W  = 8;
   localparam int H  = 8;
   localparam int WW = K * K * DW;
   localparam int WINS_PER_FRAME = (H - K + 1) * (W - K + 1);

   typedef struct {
      logic [WW-1:0] w;
      int            row;
      int            col;
      bit            last;
   } win_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] pix_in;
   logic          pix_valid;
   logic          pix_ready;
   logic [WW-1:0] window_out;
   logic          win_valid;
   logic          win_ready;
   logic [15:0]   win_row;
   logic [15:0]   win_col;
   logic          win_last;
`ifdef WINBUF_STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   conv_window_buffer #(.DATA_W(DW), .K(K), .IMG_W(W), .IMG_H(H)) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .window_out (window_out),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_row    (win_row),
      .win_col    (win_col),
      .win_last   (win_last)
`ifdef WINBUF_STALL_CNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] elem(input logic [WW-1:0] w, input int r, input int c);
      return w[(r*K+c)*DW +: DW];
   endfunction

   // ---------------- model + compare ----------------
   logic [DW-1:0] img [H][W];
   win_t          exp_q[$];
   win_t          got[$];
   win_t          ref_log[$];
   int            frame_acc   = 0;
   int            frame_win   = 0;
   int            hs_count    = 0;
   int            stalls_seen = 0;
   bit            have_prev   = 0;
   win_t          prev;

   always @(negedge clk) begin
      int   r, c;
      win_t e, g;
      if (rst) begin
         exp_q.delete();
         frame_acc = 0;
         frame_win = 0;
         have_prev = 0;
      end else begin
         chk("pix_ready_rule", pix_ready, !win_valid || win_ready);

         if (have_prev) begin
            chk("stall_hold_valid", win_valid, 1'b1);
            chkw("stall_hold_window", window_out, prev.w);
            chk("stall_hold_row", win_row, prev.row);
            chk("stall_hold_col", win_col, prev.col);
            chk("stall_hold_last", win_last, prev.last);
         end
         have_prev = win_valid && !win_ready;
         prev.w = window_out; prev.row = win_row; prev.col = win_col; prev.last = win_last;
         if (win_valid && !win_ready) stalls_seen++;

         if (win_valid && win_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_window", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chkw("window", window_out, e.w);
               chk("win_row", win_row, e.row);
               chk("win_col", win_col, e.col);
               chk("win_last", win_last, e.last);
            end
            // The first window of a frame is the one ending at pixel (K-1,K-1).
            if (frame_win == 0) chk("first_window_latency", frame_acc, (K-1)*W + K);
            frame_win++;
            hs_count++;
            g.w = window_out; g.row = win_row; g.col = win_col; g.last = win_last;
            got.push_back(g);
            if (win_last) begin
               chk("windows_per_frame", frame_win, WINS_PER_FRAME);
               frame_win = 0;
            end
         end

         if (pix_valid && pix_ready) begin
            r = frame_acc / W;
            c = frame_acc % W;
            img[r][c] = pix_in;
            if (r >= K-1 && c >= K-1) begin
               e.w = '0;
               for (int i = 0; i < K; i++)
                  for (int j = 0; j < K; j++)
                     e.w[(i*K+j)*DW +: DW] = img[r-(K-1)+i][c-(K-1)+j];
               e.row  = r - (K-1);
               e.col  = c - (K-1);
               e.last = (r == H-1) && (c == W-1);
               exp_q.push_back(e);
            end
            frame_acc = (frame_acc == W*H-1) ? 0 : frame_acc + 1;
         end
      end
   end

   // ---------------- win_ready driver ----------------
   int ready_mode = 0;   // 0 always ready, 1 random, 2 scripted stall
   int stall_at   = 0;
   int stall_len  = 0;
   int stall_done = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: win_ready = 1'b1;
            1: win_ready = 1'($urandom_range(1));
            default: begin
               if (win_valid && hs_count == stall_at && stall_done < stall_len) begin
                  win_ready = 1'b0;
                  stall_done++;
               end else begin
                  win_ready = 1'b1;
               end
            end
         endcase
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input int n, input int base, input int gap_pct);
      int  k = 0;
      int  guard = 0;
      bit  acc;
      while (k < n && guard < 5000) begin
         pix_valid = ($urandom_range(99) >= gap_pct);
         pix_in    = DW'(base + k);
         @(negedge clk);
         acc = pix_valid && pix_ready;
         @(posedge clk);
         #1;
         if (acc) k++;
         guard++;
      end
      pix_valid = 1'b0;
      chk("send_completed", k, n);
   endtask

   task automatic drain();
      int g = 0;
      while ((exp_q.size() != 0 || win_valid) && g < 300) begin
         @(posedge clk);
         #1;
         g++;
      end
      chk("drain_in_time", g < 300, 1);
   endtask

   task automatic pulse_rst();
      rst       = 1'b1;
      pix_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic clear_logs();
      got.delete();
      hs_count    = 0;
      stalls_seen = 0;
   endtask

   initial begin
      int lasts;
      rst       = 1'b1;
      pix_valid = 1'b0;
      pix_in    = '0;
      win_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      chk("rst_win_valid", win_valid, 0);
      chk("rst_win_last", win_last, 0);
      chk("rst_win_row", win_row, 0);
      chk("rst_win_col", win_col, 0);
      chkw("rst_window", window_out, '0);
      chk("rst_pix_ready", pix_ready, 1);

      // Test 1: one frame, pixel = row*8+col, always ready
      clear_logs();
      send(64, 0, 0);
      drain();
      chk("t1_count", got.size(), 16);
      if (got.size() == 16) begin
         chk("t1_first_00", elem(got[0].w, 0, 0), 0);
         chk("t1_first_04", elem(got[0].w, 0, 4), 4);
         chk("t1_first_40", elem(got[0].w, 4, 0), 32);
         chk("t1_first_44", elem(got[0].w, 4, 4), 36);
         chk("t1_first_row", got[0].row, 0);
         chk("t1_first_col", got[0].col, 0);
         chk("t1_first_last", got[0].last, 0);
         chk("t1_last_44", elem(got[15].w, 4, 4), 63);
         chk("t1_last_00", elem(got[15].w, 0, 0), 27);
         chk("t1_last_row", got[15].row, 3);
         chk("t1_last_col", got[15].col, 3);
         chk("t1_last_flag", got[15].last, 1);
      end
      ref_log = got;

      // Test 2: same frame, win_ready low 3 cycles on the second window
      clear_logs();
      stall_at = 1; stall_len = 3; stall_done = 0; ready_mode = 2;
      send(64, 0, 0);
      drain();
      ready_mode = 0;
      chk("t2_stall_cycles", stalls_seen, 3);
      chk("t2_count", got.size(), 16);
      if (got.size() == 16 && ref_log.size() == 16)
         for (int i = 0; i < 16; i++) begin
            chkw("t2_same_as_unstalled", got[i].w, ref_log[i].w);
         end

      // Test 3: two back-to-back frames, values 0..127
      clear_logs();
      send(128, 0, 0);
      drain();
      chk("t3_count", got.size(), 32);
      if (got.size() == 32) begin
         chk("t3_f2_first_00", elem(got[16].w, 0, 0), 64);
         chk("t3_f2_first_44", elem(got[16].w, 4, 4), 100);
         chk("t3_f2_first_row", got[16].row, 0);
         chk("t3_f2_first_col", got[16].col, 0);
         chk("t3_f1_last_flag", got[15].last, 1);
      end

      // Test 4: random input gaps and random downstream ready, two frames
      clear_logs();
      ready_mode = 1;
      send(128, 1000, 50);
      ready_mode = 0;
      drain();
      chk("t4_count", got.size(), 32);
      lasts = 0;
      foreach (got[i]) if (got[i].last) lasts++;
      chk("t4_last_flags", lasts, 2);

      // Test 5: reset after 40 pixels, then a fresh frame
      clear_logs();
      send(40, 300, 0);
      pulse_rst();
      chk("t5_rst_win_valid", win_valid, 0);
      chk("t5_rst_win_row", win_row, 0);
      chk("t5_rst_win_col", win_col, 0);
      chk("t5_rst_win_last", win_last, 0);
      chkw("t5_rst_window", window_out, '0);
      clear_logs();
      send(64, 500, 0);
      drain();
      chk("t5_count", got.size(), 16);
      if (got.size() == 16) begin
         chk("t5_first_00", elem(got[0].w, 0, 0), 500);
         chk("t5_first_44", elem(got[0].w, 4, 4), 536);
         chk("t5_first_row", got[0].row, 0);
      end

`ifdef WINBUF_STALL_CNT_EN
      // Stall counter: 5 injected stall cycles, cleared only by rst
      pulse_rst();
      chk("sc_after_rst", stall_cnt, 0);
      clear_logs();
      stall_at = 0; stall_len = 5; stall_done = 0; ready_mode = 2;
      send(64, 0, 0);
      drain();
      ready_mode = 0;
      chk("sc_stall_seen", stalls_seen, 5);
      chk("sc_count", stall_cnt, 5);
      pulse_rst();
      chk("sc_cleared", stall_cnt, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
